// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the FFT bit-reverse reorder stage.
// Ports: start_ip/ip_re/ip_im in; op_re/op_im/op_valid/start_op/restart_err out.
interface fft_bitrev_reorder_if #(
  parameter int W = 32
);
  logic         start_ip;
  logic [W-1:0] ip_re;
  logic [W-1:0] ip_im;
  logic [W-1:0] op_re;
  logic [W-1:0] op_im;
  logic         op_valid;
  logic         start_op;
  logic         restart_err;

  modport master (
    output start_ip, ip_re, ip_im,
    input  op_re, op_im, op_valid,
    input  start_op, restart_err
  );

  modport slave (
    input  start_ip, ip_re, ip_im,
    output op_re, op_im, op_valid,
    output start_op, restart_err
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder of bit-reversed SDF FFT output frames into natural order.
// Ports: clk, rst (async, active-high), io (slave: start_ip, ip_re/ip_im in;
//   op_re/op_im, op_valid, start_op, sticky restart_err out).
// Option: define BITREV_NORM_EN to scale outputs by 1/2^N (arith shift).
module fft_bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 32
) (
  input logic               clk,
  input logic               rst,
  fft_bitrev_reorder_if.slave io
);

  localparam int D = 1 << N;

  typedef enum logic { WIDLE, FILL }  wr_state_t;
  typedef enum logic { RIDLE, DRAIN } rd_state_t;

  wr_state_t    wr_state, wr_state_d;
  logic [N-1:0] wr_cnt, wr_cnt_d;
  logic         wr_bank, wr_bank_d;
  logic         err_q, err_d;
  logic         wr_en;
  logic [N-1:0] wr_addr;
  logic         launch;

  rd_state_t    rd_state, rd_state_d;
  logic [N-1:0] rd_cnt, rd_cnt_d;
  logic         rd_bank, rd_bank_d;
  logic         rd_en;
  logic [2*W-1:0] rd_data;
  logic [W-1:0] rd_re, rd_im;

  logic [W-1:0] op_re_q, op_im_q;
  logic         op_valid_q, start_op_q;

  logic [2*W-1:0] mem [2][D];

  function automatic logic [N-1:0] bitrev(
    input logic [N-1:0] a
  );
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = a[N-1-i];
    end
    return r;
  endfunction

  // Write FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= WIDLE;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_state <= wr_state_d;
      wr_cnt   <= wr_cnt_d;
      wr_bank  <= wr_bank_d;
      err_q    <= err_d;
    end
  end

  // Write FSM: next state. start_ip always wins, so a
  // start mid-fill restarts the frame in the same bank.
  always_comb begin
    wr_state_d = wr_state;
    wr_cnt_d   = wr_cnt;
    wr_bank_d  = wr_bank;
    err_d      = err_q;
    unique case (1'b1)
      io.start_ip: begin
        wr_state_d = FILL;
        wr_cnt_d   = N'(1);
        if (wr_state == FILL) err_d = 1'b1;
      end
      (!io.start_ip && wr_state == FILL): begin
        wr_cnt_d = wr_cnt + 1'b1;
        if (wr_cnt == '1) begin
          wr_state_d = WIDLE;
          wr_bank_d  = ~wr_bank;
        end
      end
      default: ;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    launch  = 1'b0;
    unique case (1'b1)
      io.start_ip: begin
        wr_en = 1'b1;
      end
      (!io.start_ip && wr_state == FILL): begin
        wr_en   = 1'b1;
        wr_addr = bitrev(wr_cnt);
        launch  = (wr_cnt == '1);
      end
      default: ;
    endcase
  end

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= {io.ip_re, io.ip_im};
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RIDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      rd_cnt   <= rd_cnt_d;
      rd_bank  <= rd_bank_d;
    end
  end

  // Read FSM: next state. A launch on the last drain
  // cycle chains straight into the next frame.
  always_comb begin
    rd_state_d = rd_state;
    rd_cnt_d   = rd_cnt;
    rd_bank_d  = rd_bank;
    unique case (1'b1)
      launch: begin
        rd_state_d = DRAIN;
        rd_cnt_d   = '0;
        rd_bank_d  = wr_bank;
      end
      (!launch && rd_state == DRAIN): begin
        rd_cnt_d = rd_cnt + 1'b1;
        if (rd_cnt == '1) rd_state_d = RIDLE;
      end
      default: ;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    rd_en   = (rd_state == DRAIN);
    rd_data = mem[rd_bank][rd_cnt];
`ifdef BITREV_NORM_EN
    rd_re   = W'($signed(rd_data[2*W-1:W]) >>> N);
    rd_im   = W'($signed(rd_data[W-1:0]) >>> N);
`else
    rd_re   = rd_data[2*W-1:W];
    rd_im   = rd_data[W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_re_q    <= '0;
      op_im_q    <= '0;
      op_valid_q <= 1'b0;
      start_op_q <= 1'b0;
    end else begin
      op_re_q    <= rd_en ? rd_re : '0;
      op_im_q    <= rd_en ? rd_im : '0;
      op_valid_q <= rd_en;
      start_op_q <= rd_en && (rd_cnt == '0);
    end
  end

  assign io.op_re       = op_re_q;
  assign io.op_im       = op_im_q;
  assign io.op_valid    = op_valid_q;
  assign io.start_op    = start_op_q;
  assign io.restart_err = err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed self-checking bench for fft_bitrev_reorder (N=3, W=32).
// Covers ramp, back-to-back, restart, reset mid-drain, sign/normalise.
module tb_fft_bitrev_reorder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_r [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_bitrev_reorder_if #(.W(32)) bus ();

  fft_bitrev_reorder #(.N(3), .W(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(
    input logic        s,
    input logic [31:0] re,
    input logic [31:0] im
  );
    bus.start_ip = s;
    bus.ip_re    = re;
    bus.ip_im    = im;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start_ip = 1'b0;
    bus.ip_re    = '0;
    bus.ip_im    = '0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.op_valid), 0);
    chk("rst_start", 32'(bus.start_op), 0);
    chk("rst_re", bus.op_re, 0);
    chk("rst_im", bus.op_im, 0);
    chk("rst_err", 32'(bus.restart_err), 0);
    rst = 1'b0;
    cyc(0, 0, 0);

    // Ramp
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, k, 0);
      chk("ramp_fill_valid", 32'(bus.op_valid), 0);
    end
    for (int j = 0; j < 8; j++) begin
      cyc(0, 0, 0);
      chk("ramp_valid", 32'(bus.op_valid), 1);
      chk("ramp_re", bus.op_re, exp_r[j]);
      chk("ramp_im", bus.op_im, 0);
      chk("ramp_start", 32'(bus.start_op), (j == 0));
    end
    cyc(0, 0, 0);
    chk("ramp_end_valid", 32'(bus.op_valid), 0);
    chk("ramp_end_re", bus.op_re, 0);
    chk("ramp_err", 32'(bus.restart_err), 0);

    // Back-to-back
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, k, 100 + k);
    end
    for (int j = 0; j < 8; j++) begin
      cyc(j == 0, j + 16, 116 + j);
      chk("b2b_f0_valid", 32'(bus.op_valid), 1);
      chk("b2b_f0_re", bus.op_re, exp_r[j]);
      chk("b2b_f0_im", bus.op_im, 100 + exp_r[j]);
      chk("b2b_f0_start", 32'(bus.start_op), (j == 0));
    end
    for (int j = 0; j < 8; j++) begin
      cyc(0, 0, 0);
      chk("b2b_f1_valid", 32'(bus.op_valid), 1);
      chk("b2b_f1_re", bus.op_re, 16 + exp_r[j]);
      chk("b2b_f1_im", bus.op_im, 116 + exp_r[j]);
      chk("b2b_f1_start", 32'(bus.start_op), (j == 0));
    end
    cyc(0, 0, 0);
    chk("b2b_end_valid", 32'(bus.op_valid), 0);
    chk("b2b_err", 32'(bus.restart_err), 0);

    // Sign / normalisation: sample 0 = -8.0, sample 4 = 64
    cyc(1, 32'hFFF8_0000, 32'h0008_0000);
    for (int k = 1; k < 8; k++) begin
      cyc(0, 16 * k, 0);
    end
    cyc(0, 0, 0);
`ifdef BITREV_NORM_EN
    chk("norm_x0_re", bus.op_re, 32'hFFFF_0000);
    chk("norm_x0_im", bus.op_im, 32'h0001_0000);
`else
    chk("norm_x0_re", bus.op_re, 32'hFFF8_0000);
    chk("norm_x0_im", bus.op_im, 32'h0008_0000);
`endif
    chk("norm_x0_start", 32'(bus.start_op), 1);
    cyc(0, 0, 0);
`ifdef BITREV_NORM_EN
    chk("norm_x1_re", bus.op_re, 8);
`else
    chk("norm_x1_re", bus.op_re, 64);
`endif
    repeat (7) cyc(0, 0, 0);
    chk("norm_end_valid", 32'(bus.op_valid), 0);

    // Restart: start at t0 and again at t0+3
    cyc(1, 9, 9);
    cyc(0, 9, 9);
    cyc(0, 9, 9);
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, k, 0);
      chk("rs_fill_valid", 32'(bus.op_valid), 0);
    end
    chk("rs_err", 32'(bus.restart_err), 1);
    for (int j = 0; j < 8; j++) begin
      cyc(0, 0, 0);
      chk("rs_valid", 32'(bus.op_valid), 1);
      chk("rs_re", bus.op_re, exp_r[j]);
      chk("rs_start", 32'(bus.start_op), (j == 0));
    end
    cyc(0, 0, 0);
    chk("rs_end_valid", 32'(bus.op_valid), 0);
    chk("rs_err_sticky", 32'(bus.restart_err), 1);

    // Reset mid-drain at t0+10
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, 50 + k, 7);
    end
    for (int j = 0; j < 3; j++) begin
      cyc(0, 0, 0);
      chk("rd_pre_re", bus.op_re, 50 + exp_r[j]);
    end
    rst = 1'b1;
    #1;
    chk("rd_rst_valid", 32'(bus.op_valid), 0);
    chk("rd_rst_start", 32'(bus.start_op), 0);
    chk("rd_rst_re", bus.op_re, 0);
    chk("rd_rst_im", bus.op_im, 0);
    chk("rd_rst_err", 32'(bus.restart_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc(0, 0, 0);
      chk("rd_quiet_valid", 32'(bus.op_valid), 0);
    end

    // Frame after reset
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, 32 + k, 0);
    end
    for (int j = 0; j < 8; j++) begin
      cyc(0, 0, 0);
      chk("post_re", bus.op_re, 32 + exp_r[j]);
      chk("post_start", 32'(bus.start_op), (j == 0));
    end
    cyc(0, 0, 0);
    chk("post_end_valid", 32'(bus.op_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

- Output reorder stage placed directly after the last radix-2 SDF butterfly stage (n = N).
- The SDF pipeline emits X[k] in bit-reversed index order; this block reorders each 2^N-sample frame into natural order.
- Uses a ping-pong pair of complex sample banks, so one frame can be written while the previous frame is read out. Streaming is continuous with no stalls.
- Data is the codebase's 32-bit Q16.16 fixed-point format, carried as separate real and imaginary words.

## Interface
Parameters:
- N, 3, log2 of FFT length; frame = 2^N samples; same N as the butterfly stages.
- W, 32, width of each real/imag word (Q16.16 at W=32).

Ports:
- clk  input  1  Single clock; all logic on its rising edge.
- rst  input  1  Reset, asynchronous, active-high.
- start_ip  input  1  One-cycle pulse from the last butterfly stage's start_op; marks sample 0 of a frame.
- ip_re  input  W  Real part of the incoming sample (bit-reversed order).
- ip_im  input  W  Imaginary part of the incoming sample.
- op_re  output  W  Real part of the outgoing sample (natural order); 0 when op_valid=0.
- op_im  output  W  Imaginary part of the outgoing sample; 0 when op_valid=0.
- op_valid  output  1  High for the 2^N consecutive output cycles of a frame.
- start_op  output  1  One-cycle pulse coincident with output X[0] of a frame.
- restart_err  output  1  Sticky flag set when start_ip arrives while a fill is in progress. Cleared only by rst.

## Operation
Storage:
- Two banks, bank 0 and bank 1, each 2^N entries × 2W bits.
- wr_bank selects the bank being written; rd_bank selects the bank being read.

Write FSM (states WIDLE, FILL):
- WIDLE + start_ip: write ip into wr_bank at address bitrev_N(0) = 0; set wr_cnt = 1; go to FILL.
- FILL, every cycle: write ip at address bitrev_N(wr_cnt); increment wr_cnt.
- FILL, after the write with wr_cnt = 2^N−1:
  - hand wr_bank to the read side (rd_bank ← wr_bank, read launch);
  - toggle wr_bank;
  - go to WIDLE.
- FILL + start_ip:
  - abort the partial frame; set restart_err;
  - treat this cycle as sample 0 of a new frame in the same wr_bank (address 0, wr_cnt = 1);
  - no launch occurs for the aborted frame.
- bitrev_N(a) reverses the low N bits of a.
- Samples are taken every cycle while in FILL; there is no input valid or back-pressure.

Read FSM (states RIDLE, DRAIN):
- Read launch: load rd_cnt = 0 and enter DRAIN.
- DRAIN, every cycle: read address rd_cnt; increment rd_cnt.
- DRAIN exits to RIDLE after rd_cnt = 2^N−1, unless a new launch arrives in that same cycle; then it stays in DRAIN with rd_cnt = 0.

Output register:
- op_re/op_im, op_valid and start_op are registered.
- start_op = 1 exactly when the registered sample is rd_cnt = 0.

Ping-pong safety:
- A fill takes ≥ 2^N cycles and a drain takes exactly 2^N cycles, so a drain always finishes before its bank is rewritten. No overlap check is required.

Reset:
- All outputs 0; restart_err 0.
- Both FSMs idle; wr_bank = 0; counters 0.
- Bank contents are not cleared.
- Reset mid-fill or mid-drain discards all in-flight frames.

## Timing
- Sample 0 enters at cycle t0 (start_ip high); sample k enters at t0+k.
- Read launch occurs at t0+2^N−1.
- Output X[j] is registered at t0+2^N+j; start_op and the first op_valid fall in cycle t0+2^N.
- Latency from sample-0 input to X[0] output: 2^N cycles.
- Back-to-back frames (next start_ip at t0+2^N) give continuous output: op_valid stays high with no gap, and start_op pulses every 2^N cycles.

## Configuration
- BITREV_NORM_EN defined:
  - op_re/op_im are arithmetic-shifted right by N bits (×1/2^N, truncate toward −∞) in the output register stage;
  - latency is unchanged.
- BITREV_NORM_EN undefined: samples pass through unscaled.

## Test plan
All scenarios use N=3.
- Ramp: start_ip at t0, ip_re = k (k = 0..7), ip_im = 0 → from t0+8, op_re = 0,4,2,6,1,5,3,7; op_valid high for 8 cycles; start_op only at t0+8.
- Back-to-back: two frames (ip_re = k, then k+16) with start_ip at t0 and t0+8 → 16 continuous valid outputs; second frame reads 16,20,18,22,17,21,19,23; start_op at t0+8 and t0+16.
- Restart: start_ip at t0 and again at t0+3, then ramp from t0+3 → restart_err = 1; exactly one frame is output, starting at t0+11 with op_re = 0,4,2,6,1,5,3,7.
- Reset mid-drain: assert rst at t0+10 → op_valid, start_op, op_re and op_im are 0 immediately; no further outputs until a new start_ip.
- Sign/normalisation: with BITREV_NORM_EN, sample 0 = 0xFFF8_0000 (−8.0) → X[0] = 0xFFFF_0000 (−1.0); without the macro, X[0] = 0xFFF8_0000.
